// File: rtl/sp_ram_bist.sv
// March C- self-test initiator for a single-port SRAM with 1-cycle read latency.
// Optional macro SP_RAM_BIST_ERR_CNT_EN adds a saturating 16-bit mismatch counter (err_cnt_o).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i, RAM port quiet, result flags held
// RUN   | issuing march accesses, one per cycle, elements back to back
// DRAIN | RAM port quiet for one cycle while the final read is compared
module sp_ram_bist #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [2:0]              fail_elem_o,
`ifdef SP_RAM_BIST_ERR_CNT_EN
  output logic [15:0]             err_cnt_o,
`endif
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFS      = $clog2(BYTES);
  localparam int WA       = ADDR_WIDTH - OFS;
  localparam int WORD_NUM = 2 ** WA;
  localparam logic [WA-1:0] ADDR_LAST = WA'(WORD_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [WA-1:0]         addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic                  cmp_exp_q, cmp_exp_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]            cmp_elem_q, cmp_elem_d;
`ifdef SP_RAM_BIST_ERR_CNT_EN
  logic [15:0]           err_cnt_q, err_cnt_d;
`endif

  logic                  single_op, down, last_addr, op_write, wr_one, rd_one, mismatch;
  logic [ADDR_WIDTH-1:0] acc_addr;

  // E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 r0
  assign single_op = (elem_q == 3'd0) || (elem_q == 3'd5);
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last_addr = down ? (addr_q == '0) : (addr_q == ADDR_LAST);
  assign op_write  = (elem_q == 3'd0) || (!single_op && phase_q);
  assign wr_one    = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign rd_one    = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign acc_addr  = ADDR_WIDTH'(addr_q) << OFS;
  assign mismatch  = cmp_vld_q && (ram_rdata_i != {DATA_WIDTH{cmp_exp_q}});

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
`ifdef SP_RAM_BIST_ERR_CNT_EN
  assign err_cnt_o   = err_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    cmp_vld_d   = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
`ifdef SP_RAM_BIST_ERR_CNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;

    if (mismatch) begin
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
`ifdef SP_RAM_BIST_ERR_CNT_EN
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          phase_d     = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
`ifdef SP_RAM_BIST_ERR_CNT_EN
          err_cnt_d   = 16'd0;
`endif
        end
      end
      S_RUN: begin
        ram_en_o   = 1'b1;
        ram_we_o   = op_write;
        ram_addr_o = acc_addr;
        ram_be_o   = '1;
        if (op_write) begin
          ram_wdata_o = {DATA_WIDTH{wr_one}};
        end else begin
          cmp_vld_d  = 1'b1;
          cmp_exp_d  = rd_one;
          cmp_addr_d = acc_addr;
          cmp_elem_d = elem_q;
        end
        if (!single_op && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_addr) begin
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              // the next element runs downward only after E2 and E3
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : '0;
            end
          end else begin
            addr_d = down ? (addr_q - WA'(1)) : (addr_q + WA'(1));
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
`ifdef SP_RAM_BIST_ERR_CNT_EN
      err_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
`ifdef SP_RAM_BIST_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

endmodule
